ps2_key_event_decoder: RTL and testbench

Sits between the PS/2 keyboard receiver and the display/ASCII logic. It pops scan-code bytes from the receiver and decodes make, break, E0-extended and E0-F0 sequences into key events. It tracks the held key, modifier state and a press counter, and buffers key events in a parametrised FIFO with a valid/ready output.

---
 rtl/ps2_key_event_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_key_event_decoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code byte decoder: make/break/E0 sequences -> key events buffered in a small FIFO.
// Optional macro TYPEMATIC_FILTER_EN discards auto-repeat makes of the currently held key.
module ps2_key_event_decoder #(
  parameter int unsigned COUNT_W   = 8,
  parameter int unsigned EVT_DEPTH = 8,
  parameter int unsigned EVT_AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_ready,
  output logic               rx_nextdata_n,
  input  logic               rx_overflow,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [7:0]         evt_code,
  output logic               evt_ext,
  output logic               evt_break,
  output logic [7:0]         held_code,
  output logic               held_ext,
  output logic               shift,
  output logic               ctrl,
  output logic [COUNT_W-1:0] press_count,
  output logic               evt_dropped,
  output logic               rx_lost
);

  localparam int unsigned CNT_W = EVT_AW + 1;
  localparam logic [7:0] B_EXT    = 8'hE0;
  localparam logic [7:0] B_BRK    = 8'hF0;
  localparam logic [7:0] B_LSHIFT = 8'h12;
  localparam logic [7:0] B_RSHIFT = 8'h59;
  localparam logic [7:0] B_CTRL   = 8'h14;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  state_t               state_q, state_d;
  logic                 nextdata_n_q, nextdata_n_d;
  evt_t                 mem_q [EVT_DEPTH];
  logic [EVT_AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  evt_t                 head_q, head_d;
  logic                 valid_q, valid_d;
  logic [7:0]           held_code_q, held_code_d;
  logic                 held_ext_q, held_ext_d;
  logic                 shift_q, shift_d, ctrl_q, ctrl_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 dropped_q, dropped_d, lost_q, lost_d;

  logic pop, do_make, do_break, ev_ext, is_shift, is_ctrl, repeat_make;
  logic enq, enq_ok, deq, full;
  evt_t new_evt;

  // Byte handshake, prefix decoding, key state and FIFO bookkeeping
  always_comb begin
    state_d      = state_q;
    held_code_d  = held_code_q;
    held_ext_d   = held_ext_q;
    shift_d      = shift_q;
    ctrl_d       = ctrl_q;
    count_d      = count_q;
    dropped_d    = dropped_q;
    lost_d       = lost_q | rx_overflow;
    do_make      = 1'b0;
    do_break     = 1'b0;
    enq          = 1'b0;
    pop          = rx_ready & nextdata_n_q;
    nextdata_n_d = ~pop;
    ev_ext       = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    is_shift     = ~ev_ext & ((rx_data == B_LSHIFT) || (rx_data == B_RSHIFT));
    is_ctrl      = (rx_data == B_CTRL);
    new_evt      = '{code: rx_data, ext: ev_ext, brk: (state_q == S_BRK) || (state_q == S_EXT_BRK)};

    if (pop) begin
      if ((rx_data == 8'h00) || (rx_data == 8'hFF)) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rx_data == B_EXT)      state_d = S_EXT;
            else if (rx_data == B_BRK) state_d = S_BRK;
            else                       do_make = 1'b1;
          end
          S_EXT: begin
            if (rx_data == B_EXT)      state_d = S_EXT;
            else if (rx_data == B_BRK) state_d = S_EXT_BRK;
            else begin
              do_make = 1'b1;
              state_d = S_IDLE;
            end
          end
          default: begin
            // A stray E0 after a break prefix restarts an extended sequence
            if (rx_data == B_EXT) state_d = S_EXT;
            else begin
              do_break = 1'b1;
              state_d  = S_IDLE;
            end
          end
        endcase
      end
    end

`ifdef TYPEMATIC_FILTER_EN
    repeat_make = (rx_data == held_code_q) && (ev_ext == held_ext_q);
`else
    repeat_make = 1'b0;
`endif

    if (do_make && !repeat_make) begin
      count_d     = count_q + COUNT_W'(1);
      held_code_d = rx_data;
      held_ext_d  = ev_ext;
      if (is_shift) shift_d = 1'b1;
      if (is_ctrl)  ctrl_d  = 1'b1;
      enq = 1'b1;
    end
    if (do_break) begin
      if (is_shift) shift_d = 1'b0;
      if (is_ctrl)  ctrl_d  = 1'b0;
      if ((rx_data == held_code_q) && (ev_ext == held_ext_q)) begin
        held_code_d = 8'h00;
        held_ext_d  = 1'b0;
      end
      enq = 1'b1;
    end

    deq    = valid_q & evt_ready;
    full   = (cnt_q == CNT_W'(EVT_DEPTH));
    enq_ok = enq & (~full | deq);
    if (enq & ~enq_ok) dropped_d = 1'b1;

    rd_ptr_d = rd_ptr_q + EVT_AW'(deq);
    wr_ptr_d = wr_ptr_q + EVT_AW'(enq_ok);
    cnt_d    = cnt_q + CNT_W'(enq_ok) - CNT_W'(deq);
    valid_d  = (cnt_d != '0);
    // Head register mirrors the post-update FIFO head; bypass when it is the slot being written
    if (!valid_d)                           head_d = '0;
    else if (enq_ok && wr_ptr_q == rd_ptr_d) head_d = new_evt;
    else                                    head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      nextdata_n_q <= 1'b1;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      head_q       <= '0;
      valid_q      <= 1'b0;
      held_code_q  <= '0;
      held_ext_q   <= 1'b0;
      shift_q      <= 1'b0;
      ctrl_q       <= 1'b0;
      count_q      <= '0;
      dropped_q    <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      nextdata_n_q <= nextdata_n_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      head_q       <= head_d;
      valid_q      <= valid_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
      shift_q      <= shift_d;
      ctrl_q       <= ctrl_d;
      count_q      <= count_d;
      dropped_q    <= dropped_d;
      lost_q       <= lost_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(EVT_DEPTH); i++) mem_q[i] <= '0;
    end else if (enq_ok) begin
      mem_q[wr_ptr_q] <= new_evt;
    end
  end

  assign rx_nextdata_n = nextdata_n_q;
  assign evt_valid     = valid_q;
  assign evt_code      = head_q.code;
  assign evt_ext       = head_q.ext;
  assign evt_break     = head_q.brk;
  assign held_code     = held_code_q;
  assign held_ext      = held_ext_q;
  assign shift         = shift_q;
  assign ctrl          = ctrl_q;
  assign press_count   = count_q;
  assign evt_dropped   = dropped_q;
  assign rx_lost       = lost_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: prefix-flag reference model with per-cycle compare, plus literal checks.
module tb_ps2_key_event_decoder;

  localparam int unsigned COUNT_W   = 8;
  localparam int unsigned EVT_DEPTH = 8;
  localparam int unsigned EVT_AW    = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [7:0]         rx_data = 8'h00;
  logic               rx_ready = 1'b0;
  logic               rx_overflow = 1'b0;
  logic               evt_ready = 1'b0;
  logic               rx_nextdata_n, evt_valid, evt_ext, evt_break, held_ext, shift, ctrl;
  logic               evt_dropped, rx_lost;
  logic [7:0]         evt_code, held_code;
  logic [COUNT_W-1:0] press_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int low_cnt = 0;
  logic [9:0] got [$];

  always #5 clk = ~clk;

  ps2_key_event_decoder #(.COUNT_W(COUNT_W), .EVT_DEPTH(EVT_DEPTH), .EVT_AW(EVT_AW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_nextdata_n(rx_nextdata_n), .rx_overflow(rx_overflow),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .held_code(held_code),
    .held_ext(held_ext), .shift(shift), .ctrl(ctrl), .press_count(press_count),
    .evt_dropped(evt_dropped), .rx_lost(rx_lost)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [9:0] ev(input logic [7:0] c, input logic e, input logic b);
    return {c, e, b};
  endfunction

  // Reference model: two prefix flags plus a queue for the event buffer
  logic [9:0]         mq [$];
  bit                 m_ext, m_brk, m_popped;
  logic [7:0]         m_held;
  bit                 m_hext, m_shift, m_ctrl, m_drop, m_lost;
  logic [COUNT_W-1:0] m_count;

  task automatic model_event(input logic [7:0] c, input bit e, input bit b);
    bit is_sh, is_ct, filt;
    is_sh = !e && (c == 8'h12 || c == 8'h59);
    is_ct = (c == 8'h14);
    if (b) begin
      if (is_sh) m_shift = 0;
      if (is_ct) m_ctrl = 0;
      if (c == m_held && e == m_hext) begin m_held = 8'h00; m_hext = 0; end
    end else begin
`ifdef TYPEMATIC_FILTER_EN
      filt = (c == m_held && e == m_hext);
`else
      filt = 0;
`endif
      if (filt) return;
      m_count = m_count + 1'b1;
      m_held = c; m_hext = e;
      if (is_sh) m_shift = 1;
      if (is_ct) m_ctrl = 1;
    end
    if (mq.size() < EVT_DEPTH) mq.push_back(ev(c, e, b));
    else m_drop = 1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h00 || b == 8'hFF) begin m_ext = 0; m_brk = 0; end
    else if (b == 8'hE0) begin m_ext = 1; m_brk = 0; end
    else if (b == 8'hF0 && !m_brk) m_brk = 1;
    else begin model_event(b, m_ext, m_brk); m_ext = 0; m_brk = 0; end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ext = 0; m_brk = 0; m_popped = 0; m_held = 8'h00; m_hext = 0;
      m_shift = 0; m_ctrl = 0; m_drop = 0; m_lost = 0; m_count = '0;
    end else begin
      if (rx_overflow) m_lost = 1;
      if (evt_ready && mq.size() > 0) void'(mq.pop_front());
      if (rx_ready && !m_popped) begin
        m_popped = 1;
        model_byte(rx_data);
      end else m_popped = 0;
    end
  end

  // Collect dequeued events for literal checks
  always @(posedge clk)
    if (!rst && evt_valid && evt_ready) got.push_back({evt_code, evt_ext, evt_break});

  always @(negedge clk)
    if (chk_en && !rx_nextdata_n) low_cnt++;

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("evt_valid", 32'(evt_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) check("evt_head", 32'({evt_code, evt_ext, evt_break}), 32'(mq[0]));
      check("rx_nextdata_n", 32'(rx_nextdata_n), 32'(!m_popped));
      check("held_code", 32'(held_code), 32'(m_held));
      check("held_ext", 32'(held_ext), 32'(m_hext));
      check("shift", 32'(shift), 32'(m_shift));
      check("ctrl", 32'(ctrl), 32'(m_ctrl));
      check("press_count", 32'(press_count), 32'(m_count));
      check("evt_dropped", 32'(evt_dropped), 32'(m_drop));
      check("rx_lost", 32'(rx_lost), 32'(m_lost));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    bit done;
    done = 0;
    rx_data  = b;
    rx_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!rx_nextdata_n) done = 1;
    end
    if (!done) check("pop_timeout", 32'd1, 32'd0);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    got.delete();
  endtask

  initial begin
    logic [7:0] codes [9];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    idle(3);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_nextdata_n", 32'(rx_nextdata_n), 32'd1);
    check("rst_count", 32'(press_count), 32'd0);
    check("rst_held", 32'(held_code), 32'd0);

    // Make/break of a plain key
    evt_ready = 1'b1;
    low_cnt = 0;
    send(8'h1C);
    check("t1_held_make", 32'(held_code), 32'h1C);
    send(8'hF0); send(8'h1C);
    idle(3);
    check("t1_nevt", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check("t1_ev0", 32'(got[0]), 32'(ev(8'h1C, 0, 0)));
      check("t1_ev1", 32'(got[1]), 32'(ev(8'h1C, 0, 1)));
    end
    check("t1_count", 32'(press_count), 32'd1);
    check("t1_held_brk", 32'(held_code), 32'h00);
    check("t1_pops", 32'(low_cnt), 32'd3);

    // Extended key
    do_reset();
    send(8'hE0); send(8'h75);
    check("t2_held_ext", 32'(held_ext), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h75);
    idle(3);
    check("t2_nevt", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check("t2_ev0", 32'(got[0]), 32'(ev(8'h75, 1, 0)));
      check("t2_ev1", 32'(got[1]), 32'(ev(8'h75, 1, 1)));
    end
    check("t2_held_ext_clr", 32'(held_ext), 32'd0);

    // Modifiers
    do_reset();
    send(8'h12);
    check("t3_shift_on", 32'(shift), 32'd1);
    send(8'h1C); send(8'hF0); send(8'h12);
    check("t3_shift_off", 32'(shift), 32'd0);
    check("t3_held", 32'(held_code), 32'h1C);
    send(8'hE0); send(8'h14);
    check("t3_ctrl_on", 32'(ctrl), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h14);
    check("t3_ctrl_off", 32'(ctrl), 32'd0);

    // Auto-repeat
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C);
    idle(3);
`ifdef TYPEMATIC_FILTER_EN
    check("t4_nevt", 32'(got.size()), 32'd1);
    check("t4_count", 32'(press_count), 32'd1);
`else
    check("t4_nevt", 32'(got.size()), 32'd3);
    check("t4_count", 32'(press_count), 32'd3);
`endif

    // Overflowing the event buffer
    do_reset();
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(codes[i]);
    check("t5_dropped", 32'(evt_dropped), 32'd1);
    check("t5_count", 32'(press_count), 32'd9);
    evt_ready = 1'b1;
    idle(12);
    check("t5_nevt", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < got.size()) check("t5_order", 32'(got[i]), 32'(ev(codes[i], 0, 0)));
    check("t5_empty", 32'(evt_valid), 32'd0);

    // Enqueue and dequeue on a full buffer in the same cycle
    do_reset();
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(codes[i]);
    check("t5b_nodrop_full", 32'(evt_dropped), 32'd0);
    evt_ready = 1'b1;
    send(8'h4B);
    check("t5b_nodrop", 32'(evt_dropped), 32'd0);
    idle(12);
    check("t5b_nevt", 32'(got.size()), 32'd9);
    if (got.size() == 9) check("t5b_last", 32'(got[8]), 32'(ev(8'h4B, 0, 0)));

    // Reset discards a pending break prefix
    do_reset();
    send(8'hF0);
    do_reset();
    send(8'h1C);
    idle(3);
    check("t6_nevt", 32'(got.size()), 32'd1);
    if (got.size() == 1) check("t6_ev", 32'(got[0]), 32'(ev(8'h1C, 0, 0)));

    // Protocol errors and ignored bytes, overflow flag
    do_reset();
    send(8'hE0); send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h00); send(8'h75);
    send(8'hF0); send(8'hE0); send(8'h74);
    rx_overflow = 1'b1; idle(1); rx_overflow = 1'b0;
    idle(3);
    check("t7_nevt", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      check("t7_ev0", 32'(got[0]), 32'(ev(8'h75, 1, 0)));
      check("t7_ev1", 32'(got[1]), 32'(ev(8'h75, 0, 0)));
      check("t7_ev2", 32'(got[2]), 32'(ev(8'h74, 1, 0)));
    end
    check("t7_lost", 32'(rx_lost), 32'd1);

    // Press counter wrap
    do_reset();
    for (int i = 0; i < 255; i++) send(i[0] ? 8'h1B : 8'h1C);
    check("t8_count_ff", 32'(press_count), 32'hFF);
    send(8'h1B);
    check("t8_count_wrap", 32'(press_count), 32'h00);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
